// File: rtl/montenc_pkg.sv
// Shared types and elaboration helpers for the Montgomery-domain entry converter.
package montenc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int montenc_logq(input int logqh, input int w);
    return logqh + w;
  endfunction

  function automatic int montenc_cntw(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/montenc_if.sv
// Operand-in / result-out handshake bundle for montenc.
interface montenc_if import montenc_pkg::*; #(
  parameter int LOGQH = 26,
  parameter int W     = 34
);
  localparam int LOGQ = montenc_logq(LOGQH, W);

  logic [LOGQH-1:0] qH;
  logic             in_valid;
  logic             in_ready;
  logic [LOGQ-1:0]  A;
  logic             out_valid;
  logic             out_ready;
  logic [LOGQ-1:0]  B;

  modport master (
    output qH, in_valid, A, out_ready,
    input  in_ready, out_valid, B
  );

  modport slave (
    input  qH, in_valid, A, out_ready,
    output in_ready, out_valid, B
  );

endinterface

// File: rtl/montenc_moddbl.sv
// Combinational modular doubling: y = 2x mod q, assuming x < q.
module montenc_moddbl #(
  parameter int LOGQ = 60
) (
  input  logic [LOGQ-1:0] x,
  input  logic [LOGQ-1:0] q,
  output logic [LOGQ-1:0] y
);

  logic [LOGQ:0] d;

  // The subtraction wraps modulo 2^LOGQ, so the carried-out top bit of d is only needed for the compare.
  always_comb begin
    d = {x, 1'b0};
    y = (d >= {1'b0, q}) ? (d[LOGQ-1:0] - q) : d[LOGQ-1:0];
  end

endmodule

// File: rtl/montenc.sv
// Bit-serial Montgomery-domain entry: B = A*2^K mod q, one modular doubling per clock.
module montenc import montenc_pkg::*; #(
  parameter int LOGQH = 26,
  parameter int W     = 34,
  parameter int K     = 68
) (
  input  logic      clk,
  input  logic      rst,
  montenc_if.slave  io
);

  localparam int LOGQ = montenc_logq(LOGQH, W);
  localparam int CNTW = montenc_cntw(K);
  localparam logic [CNTW-1:0] LAST = CNTW'(K - 1);

  if (K < 1) begin : g_bad_k
    $error("montenc: K must be at least 1");
  end

  state_t          state;
  logic [LOGQ-1:0] x_r;
  logic [LOGQ-1:0] q_r;
  logic [LOGQ-1:0] x_dbl;
  logic [CNTW-1:0] cnt;
  logic            in_ready_r;
  logic            out_valid_r;

  montenc_moddbl #(.LOGQ(LOGQ)) u_dbl (
    .x (x_r),
    .q (q_r),
    .y (x_dbl)
  );

  // Low W bits of {qH, 0} are zero, so "+1" is just a set of bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x_r         <= '0;
      q_r         <= '0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid && in_ready_r) begin
            x_r        <= io.A;
            q_r        <= {io.qH, {(W-1){1'b0}}, 1'b1};
            cnt        <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          x_r <= x_dbl;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign io.in_ready  = in_ready_r;
  assign io.out_valid = out_valid_r;
  assign io.B         = x_r;

endmodule
